// File: rtl/fetch_queue_decoder.sv
// fetch_queue_decoder
//   Instruction fetch front end: issues one 32-bit fetch at a time, collects
//   the returned words in a small circular prefetch queue and decodes the
//   queue head combinationally into RV32I-style fields.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req_valid/ready     fetch request handshake
//   imem_req_addr            fetch byte address
//   imem_rsp_valid/data      response for the single outstanding request
//   redirect_valid/pc        flush the queue and restart fetch at redirect_pc
//   dec_valid/ready          head-of-queue handshake towards the consumer
//   dec_pc, dec_opcode, dec_funct3, dec_funct7, dec_rs1, dec_rs2, dec_rd,
//   dec_imm, dec_illegal     decoded head instruction (all zero when empty)
module fetch_queue_decoder #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [6:0]  dec_opcode,
    output logic [2:0]  dec_funct3,
    output logic [6:0]  dec_funct7,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [4:0]  dec_rd,
    output logic [31:0] dec_imm,
    output logic        dec_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [31:0]     req_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];

    logic req_hs;
    logic push;
    logic pop;

    // rst gates the request so nothing is issued while reset is held.
    assign imem_req_valid = !rst && (state == IDLE) && (count < CW'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign dec_valid      = (count != '0);
    // Redirect wins over both queue operations.
    assign push           = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop            = dec_valid && dec_ready && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc;
            // An in-flight request must have its response thrown away; if
            // the response shows up this very cycle it is simply not pushed.
            if (state == WAIT)
                state <= imem_rsp_valid ? IDLE : DROP;
        end else begin
            case (state)
                IDLE: if (req_hs) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                    state    <= WAIT;
                end
                WAIT: if (imem_rsp_valid) state <= IDLE;
                DROP: if (imem_rsp_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= req_pc;
            q_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    logic [31:0] instr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr = q_instr[rd_ptr];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec_pc      = '0;
        dec_opcode  = '0;
        dec_funct3  = '0;
        dec_funct7  = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_rd      = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        if (dec_valid) begin
            dec_pc     = q_pc[rd_ptr];
            dec_opcode = instr[6:0];
            case (instr[6:0])
                OP_LUI, OP_AUIPC: begin
                    dec_rd  = instr[11:7];
                    dec_imm = imm_u;
                end
                OP_JAL: begin
                    dec_rd  = instr[11:7];
                    dec_imm = imm_j;
                end
                OP_JALR, OP_LOAD: begin
                    dec_rd     = instr[11:7];
                    dec_rs1    = instr[19:15];
                    dec_funct3 = instr[14:12];
                    dec_imm    = imm_i;
                end
                OP_OPIMM: begin
                    dec_rd     = instr[11:7];
                    dec_rs1    = instr[19:15];
                    dec_funct3 = instr[14:12];
                    dec_imm    = imm_i;
                    // Only the shift-immediates carry a meaningful funct7.
                    if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
                        dec_funct7 = instr[31:25];
                end
                OP_OP: begin
                    dec_rd     = instr[11:7];
                    dec_rs1    = instr[19:15];
                    dec_rs2    = instr[24:20];
                    dec_funct3 = instr[14:12];
                    dec_funct7 = instr[31:25];
                end
                OP_STORE: begin
                    dec_rs1    = instr[19:15];
                    dec_rs2    = instr[24:20];
                    dec_funct3 = instr[14:12];
                    dec_imm    = imm_s;
                end
                OP_BRANCH: begin
                    dec_rs1    = instr[19:15];
                    dec_rs2    = instr[24:20];
                    dec_funct3 = instr[14:12];
                    dec_imm    = imm_b;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue_decoder.sv
// Bench for fetch_queue_decoder: directed stimulus with a bench-side memory,
// a queue-based reference model compared every negedge, and literal checks
// on known instructions and addresses.
module tb_fetch_queue_decoder;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    always #5 clk = ~clk;

    fetch_queue_decoder #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_opcode(dec_opcode), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_imm(dec_imm), .dec_illegal(dec_illegal)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference decode (arithmetic on field values) --------
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int si, ss, sb, sj;
        logic [31:0] su;
        bit u_rd, u_rs1, u_rs2, u_f3, u_f7;
        int isel;  // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
        si = int'(w[31:20]);                     if (si >= 2048)  si -= 4096;
        ss = int'(w[31:25]) * 32 + int'(w[11:7]); if (ss >= 2048)  ss -= 4096;
        sb = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (sb >= 4096) sb -= 8192;
        su = 32'(w[31:12]) * 32'd4096;
        sj = int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (sj >= 1048576) sj -= 2097152;
        {u_rd, u_rs1, u_rs2, u_f3, u_f7} = '0;
        isel = 0;
        d = '0;
        d.op = w[6:0];
        case (w[6:0])
            7'b0110111, 7'b0010111: begin u_rd = 1; isel = 4; end
            7'b1101111:             begin u_rd = 1; isel = 5; end
            7'b1100111, 7'b0000011: begin u_rd = 1; u_rs1 = 1; u_f3 = 1; isel = 1; end
            7'b0010011: begin
                u_rd = 1; u_rs1 = 1; u_f3 = 1; isel = 1;
                u_f7 = (w[14:12] == 3'd1) || (w[14:12] == 3'd5);
            end
            7'b0110011: begin u_rd = 1; u_rs1 = 1; u_rs2 = 1; u_f3 = 1; u_f7 = 1; end
            7'b0100011: begin u_rs1 = 1; u_rs2 = 1; u_f3 = 1; isel = 2; end
            7'b1100011: begin u_rs1 = 1; u_rs2 = 1; u_f3 = 1; isel = 3; end
            default:    d.ill = 1'b1;
        endcase
        if (u_rd)  d.rd  = w[11:7];
        if (u_rs1) d.rs1 = w[19:15];
        if (u_rs2) d.rs2 = w[24:20];
        if (u_f3)  d.f3  = w[14:12];
        if (u_f7)  d.f7  = w[31:25];
        case (isel)
            1: d.imm = 32'(si);
            2: d.imm = 32'(ss);
            3: d.imm = 32'(sb);
            4: d.imm = su;
            5: d.imm = 32'(sj);
            default: d.imm = '0;
        endcase
        return d;
    endfunction

    // ---------------- behavioural fetch/queue model -------------------------
    logic [63:0] mq[$];          // {pc, instr}, oldest first
    logic [31:0] m_fetch  = RESET_PC;
    logic [31:0] m_req_pc = '0;
    bit          m_busy   = 0;   // a request is outstanding
    bit          m_discard = 0;  // its response must be thrown away
    bit          m_hs, m_pop;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_fetch = RESET_PC; m_req_pc = '0; m_busy = 0; m_discard = 0;
        end else begin
            m_hs  = !m_busy && (mq.size() < DEPTH) && !redirect_valid && imem_req_ready;
            m_pop = (mq.size() != 0) && dec_ready;
            if (redirect_valid) begin
                mq.delete();
                m_fetch = redirect_pc;
                if (m_busy && !m_discard) begin
                    if (imem_rsp_valid) m_busy = 0;
                    else                m_discard = 1;
                end
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_busy && imem_rsp_valid) begin
                    if (!m_discard) mq.push_back({m_req_pc, imem_rsp_data});
                    m_busy = 0; m_discard = 0;
                end
                if (m_hs) begin
                    m_req_pc = m_fetch;
                    m_fetch  = m_fetch + 32'd4;
                    m_busy   = 1;
                end
            end
        end
    end

    // ---------------- compare process ---------------------------------------
    bit   e_rv;
    dec_t e_d;
    logic [31:0] e_pc;

    initial forever begin
        @(negedge clk);
        e_rv = !rst && !m_busy && (mq.size() < DEPTH) && !redirect_valid;
        chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
        if (e_rv) chk("req_addr", imem_req_addr, m_fetch);
        if (mq.size() == 0) begin
            e_d = '0; e_pc = '0;
        end else begin
            e_d = ref_decode(mq[0][31:0]); e_pc = mq[0][63:32];
        end
        chk("dec_valid",   32'(dec_valid),   32'(mq.size() != 0));
        chk("dec_pc",      dec_pc,           e_pc);
        chk("dec_opcode",  32'(dec_opcode),  32'(e_d.op));
        chk("dec_funct3",  32'(dec_funct3),  32'(e_d.f3));
        chk("dec_funct7",  32'(dec_funct7),  32'(e_d.f7));
        chk("dec_rs1",     32'(dec_rs1),     32'(e_d.rs1));
        chk("dec_rs2",     32'(dec_rs2),     32'(e_d.rs2));
        chk("dec_rd",      32'(dec_rd),      32'(e_d.rd));
        chk("dec_imm",     dec_imm,          e_d.imm);
        chk("dec_illegal", 32'(dec_illegal), 32'(e_d.ill));
    end

    // ---------------- bench memory and stimulus -----------------------------
    logic [31:0] mem [64];
    logic [6:0]  op_tab [10] = '{7'h13, 7'h23, 7'h63, 7'h33, 7'h67,
                                 7'h03, 7'h37, 7'h17, 7'h6F, 7'h0B};
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    bit          hs_seen;
    logic [31:0] hs_a;
    int          hs_cnt;
    logic [31:0] hs_addrs[$];
    bit          hit [4];

    // Literal expectations for the known words at addresses 0..C.
    task automatic probe();
        if (dec_valid) begin
            case (dec_pc)
                32'h0: begin
                    chk("lit_addi_rd", 32'(dec_rd), 32'd1);
                    chk("lit_addi_rs1", 32'(dec_rs1), 32'd0);
                    chk("lit_addi_f3", 32'(dec_funct3), 32'd0);
                    chk("lit_addi_imm", dec_imm, 32'd5);
                    chk("lit_addi_ill", 32'(dec_illegal), 32'd0);
                    hit[0] = 1;
                end
                32'h4: begin chk("lit_srai_f7", 32'(dec_funct7), 32'h20); hit[1] = 1; end
                32'h8: begin chk("lit_beq_imm", dec_imm, 32'hFFFF_FFFC); hit[2] = 1; end
                32'hC: begin
                    chk("lit_ill_flag", 32'(dec_illegal), 32'd1);
                    chk("lit_ill_imm", dec_imm, 32'd0);
                    chk("lit_ill_rd", 32'(dec_rd), 32'd0);
                    hit[3] = 1;
                end
                default: ;
            endcase
        end
    endtask

    // One clock of stimulus; the bench memory answers a handshake on the
    // following cycle unless hold delays it.
    task automatic step(input bit rdy, input bit dr, input bit redir,
                        input logic [31:0] rpc, input bit hold);
        imem_req_ready = rdy;
        dec_ready      = dr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = pend && !hold;
        imem_rsp_data  = imem_rsp_valid ? mem[pend_addr[7:2]] : 32'h0;
        @(negedge clk); #1;
        probe();
        hs_seen = imem_req_valid && imem_req_ready;
        hs_a    = imem_req_addr;
        if (hs_seen) begin hs_cnt++; hs_addrs.push_back(hs_a); end
        @(posedge clk); #1;
        if (imem_rsp_valid) pend = 0;
        if (hs_seen) begin pend = 1; pend_addr = hs_a; end
    endtask

    task automatic expect_req(input string name, input logic [31:0] addr, input bit dv);
        imem_req_ready = 0; dec_ready = 0; redirect_valid = 0; imem_rsp_valid = 0;
        #1;
        chk({name, "_valid"}, 32'(imem_req_valid), 32'd1);
        chk({name, "_addr"}, imem_req_addr, addr);
        chk({name, "_dec_valid"}, 32'(dec_valid), 32'(dv));
    endtask

    task automatic do_reset(input int cycles);
        imem_req_ready = 0; dec_ready = 0; redirect_valid = 0; imem_rsp_valid = 0;
        rst = 1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_imm", dec_imm, 32'd0);
        repeat (cycles) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_req_addr", imem_req_addr, RESET_PC);
    endtask

    dec_t d;

    initial begin
        imem_req_ready = 0; dec_ready = 0; redirect_valid = 0; redirect_pc = '0;
        imem_rsp_valid = 0; imem_rsp_data = '0;
        mem[0] = 32'h0050_0093;   // addi x1, x0, 5
        mem[1] = 32'h4020_D093;   // srai x1, x1, 2
        mem[2] = 32'hFE00_0EE3;   // beq x0, x0, -4
        mem[3] = 32'hFFFF_FFFF;   // illegal
        mem[4] = 32'h0020_A423;   // sw x2, 8(x1)
        mem[5] = 32'h1234_52B7;   // lui x5, 0x12345
        mem[6] = 32'h0100_006F;   // jal x0, 16
        mem[7] = 32'h0020_81B3;   // add x3, x1, x2
        for (int i = 8; i < 64; i++) mem[i] = {25'($urandom()), op_tab[i % 10]};

        // Pin the reference decoder itself to hand-derived values.
        d = ref_decode(32'h0050_0093);
        chk("model_addi_imm", d.imm, 32'd5);
        d = ref_decode(32'h4020_D093);
        chk("model_srai_f7", 32'(d.f7), 32'h20);
        d = ref_decode(32'hFE00_0EE3);
        chk("model_beq_imm", d.imm, 32'hFFFF_FFFC);
        d = ref_decode(32'hFFFF_FFFF);
        chk("model_ill", 32'(d.ill), 32'd1);
        d = ref_decode(32'h0020_A423);
        chk("model_sw_imm", d.imm, 32'd8);

        #1 do_reset(3);

        // Fill with the consumer stalled: exactly four fetches, then stop.
        hs_cnt = 0; hs_addrs.delete();
        for (int i = 0; i < 12; i++) step(1, 0, 0, 32'h0, 0);
        chk("fill_req_count", 32'(hs_cnt), 32'd4);
        for (int i = 0; i < 4 && i < hs_addrs.size(); i++)
            chk("fill_req_addr", hs_addrs[i], 32'(i * 4));
        chk("full_req_valid", 32'(imem_req_valid), 32'd0);
        step(0, 1, 0, 32'h0, 0);          // single pop
        expect_req("after_pop", 32'h10, 1);

        // Drain the queue.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h0, 0);

        // Redirect while WAIT; response arrives two cycles later and is dropped.
        step(1, 1, 0, 32'h0, 0);
        step(0, 1, 1, 32'h100, 1);
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 0);
        expect_req("drop_redirect", 32'h100, 0);

        // count = 2 plus a request in flight, then redirect + response + pop.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h0, 0);
        chk("pre_coinc_dec_valid", 32'(dec_valid), 32'd1);
        step(0, 1, 1, 32'h200, 0);
        expect_req("coinc_redirect", 32'h200, 0);

        // Reset in the middle of WAIT; the stale response must be ignored.
        step(1, 0, 0, 32'h0, 0);
        do_reset(2);
        step(0, 0, 0, 32'h0, 0);          // stale response delivered in IDLE
        expect_req("post_rst_stale", RESET_PC, 0);

        // Mixed traffic with back-pressure and two redirects.
        for (int i = 0; i < 40; i++)
            step(i % 4 != 1, i % 3 != 0, (i == 15) || (i == 27),
                 (i == 15) ? 32'h40 : 32'h1F8, 0);

        for (int i = 0; i < 4; i++) chk("lit_head_seen", 32'(hit[i]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
